// File: rtl/dff_input_conditioner_if.sv
// Pin-side bundle for the input conditioner: raw pins and enable in,
// debounced level and edge strobes out.
interface dff_input_conditioner_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_edge;

  modport master (output ena, din, input dout, rise, fall, any_edge);
  modport slave  (input ena, din, output dout, rise, fall, any_edge);
endinterface

// File: rtl/dff_input_conditioner.sv
// Input conditioner: 2-flop synchronizer on every pin, then a per-bit debounce
// lane that yields a registered level plus one-cycle rise/fall strobes.
module dff_ic_lane #(
  parameter int CNT_W    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  input  logic s_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any agreement, disable or acceptance clears the run; only an unbroken
  // stretch of DEBOUNCE disagreeing enabled edges moves the level.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (ena_i && (s_i != dout_q)) begin
      if (cnt_q == TERM) begin
        dout_d = s_i;
        rise_d = s_i;
        fall_d = ~s_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

module dff_input_conditioner #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dff_input_conditioner_if.slave  io
);
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] dout_w, rise_w, fall_w;

  // Synchronizer runs regardless of ena so re-enabling sees current pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= io.din;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    dff_ic_lane #(
      .CNT_W    (CNT_W),
      .DEBOUNCE (DEBOUNCE)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena_i  (io.ena),
      .s_i    (s2_q[g]),
      .dout_o (dout_w[g]),
      .rise_o (rise_w[g]),
      .fall_o (fall_w[g])
    );
  end

  assign io.dout     = dout_w;
  assign io.rise     = rise_w;
  assign io.fall     = fall_w;
  assign io.any_edge = |(rise_w | fall_w);
endmodule

// File: tb/tb_dff_input_conditioner.sv
// Scoreboard bench: each cycle the driver advances a window-based reference
// model and queues the expected outputs; a negedge monitor pops and compares.
module tb_dff_input_conditioner;
  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dff_input_conditioner_if #(.WIDTH(W)) io ();

  dff_input_conditioner #(.WIDTH(W), .CNT_W(CW), .DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  typedef struct packed {
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] s2;
    logic         en;
  } rec_t;

  exp_t         sb_q[$];
  int           tests = 0;
  int           fails = 0;

  // Reference model: din sample history, per-edge (s2, ena) records, and a
  // per-bit fence marking where the current disagreement window may start.
  logic [W-1:0] dh[$];
  rec_t         recs[$];
  int           fence[W];
  logic [W-1:0] m_dout, m_rise, m_fall;

  function automatic void model_reset();
    dh.delete();
    recs.delete();
    for (int i = 0; i < W; i++) fence[i] = 0;
    m_dout = '0;
    m_rise = '0;
    m_fall = '0;
  endfunction

  // A bit accepts a new level when its last DEB records (none before the
  // fence) are all enabled and all disagree with the current level.
  function automatic void model_edge();
    logic [W-1:0] s2;
    rec_t         r;
    bit           ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s2 = (dh.size() >= 2) ? dh[dh.size()-2] : '0;
    dh.push_back(io.din);
    r.s2 = s2;
    r.en = io.ena;
    recs.push_back(r);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      ok = (recs.size() - fence[i]) >= DEB;
      for (int k = 1; k <= DEB && ok; k++) begin
        r = recs[recs.size()-k];
        if (!r.en || (r.s2[i] == m_dout[i])) ok = 0;
      end
      if (ok) begin
        m_dout[i] = ~m_dout[i];
        m_rise[i] = m_dout[i];
        m_fall[i] = ~m_dout[i];
        fence[i]  = recs.size();
      end
    end
  endfunction

  task automatic cycle(input logic [W-1:0] d, input logic en, input logic rn);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    io.din = d;
    io.ena = en;
    rst_n  = rn;
    if (!rn) model_reset();
    e.dout = m_dout;
    e.rise = m_rise;
    e.fall = m_fall;
    sb_q.push_back(e);
  endtask

  task automatic hold(input logic [W-1:0] d, input int n);
    for (int k = 0; k < n; k++) cycle(d, 1'b1, 1'b1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic ae;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) continue;
      e  = sb_q.pop_front();
      ae = |(e.rise | e.fall);
      tests++;
      if (io.dout !== e.dout || io.rise !== e.rise || io.fall !== e.fall ||
          io.any_edge !== ae) begin
        fails++;
        $display("FAIL cmp t=%0t dout=%h/%h rise=%h/%h fall=%h/%h any=%b/%b (act/exp)",
                 $time, io.dout, e.dout, io.rise, e.rise, io.fall, e.fall,
                 io.any_edge, ae);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    int           mode;
    io.din = '1;
    io.ena = 1'b1;
    rst_n  = 1'b0;
    model_reset();

    // Reset with pins high, then release and watch the whole byte rise.
    for (int k = 0; k < 3; k++) cycle('1, 1'b1, 1'b0);
    hold('1, 10);
    hold('0, 10);
    // Clean single-bit edge and its fall.
    hold(8'h08, 10);
    hold(8'h00, 10);
    // Glitch of DEB-1 rejected, DEB accepted.
    hold(8'h01, DEB - 1);
    hold(8'h00, 10);
    hold(8'h01, DEB);
    hold(8'h00, 10);
    // Multi-bit simultaneous edge.
    hold(8'hA5, 10);
    hold(8'h00, 10);
    // Enable freeze, then release.
    for (int k = 0; k < 20; k++) cycle(8'h0F, 1'b0, 1'b1);
    hold(8'h0F, 10);
    hold(8'h00, 10);
    // Reset mid-count on bit 7.
    hold(8'h80, 4);
    cycle(8'h80, 1'b1, 1'b0);
    hold(8'h80, 10);
    hold(8'h00, 10);
    // ena dropped exactly at the would-be terminating edge.
    hold(8'h10, 5);
    cycle(8'h10, 1'b0, 1'b1);
    hold(8'h10, 10);
    hold(8'h00, 10);

    // Random phase: mix of fast glitchy and slow stable pin activity.
    d = '0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) mode = $urandom_range(0, 2);
      for (int i = 0; i < W; i++) begin
        if (mode == 0 && $urandom_range(0, 3) == 0) d[i] = ~d[i];
        if (mode != 0 && $urandom_range(0, 11) == 0) d[i] = ~d[i];
      end
      cycle(d, ($urandom_range(0, 19) != 0),
            ($urandom_range(0, 149) != 0));
    end
    hold(d, 12);

    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
